branch_resolve_unit: RTL
========================

# branch_resolve_unit

Decode-stage branch resolution for the WISC-S25 5-stage pipeline. It sits directly downstream of the IF/ID register and produces the feedback that the dynamic branch predictor (BHT + BTB) and the fetch PC mux consume. Each cycle it decodes the instruction in ID, evaluates B/BR conditions against the flags, and computes the true target. It compares the result with the fetch-time prediction and issues predictor write enables plus a PC redirect exactly once per branch instance. It stalls ID while flags or the BR source register are not yet valid, and keeps saturating branch/mispredict counters.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_advance  in  1  IF/ID may advance this cycle (all other stall sources already folded in)
- IF_ID_instr  in  16  instruction in ID
- IF_ID_PC_next  in  16  PC+2 of the ID instruction
- IF_ID_prediction  in  2  fetch-time 2-bit prediction; bit 1 = predicted taken
- IF_ID_predicted_target  in  16  fetch-time predicted target
- ZF, VF, NF  in  1 each  architectural flags
- flags_pending  in  1  a flag-writing instruction in EX has not yet written flags
- rs_data  in  16  forwarded BR source register value
- rs_ready  in  1  rs_data is valid
- is_branch  out  1  ID holds B (opcode 4'b1100) or BR (4'b1101)
- actual_taken  out  1  resolved condition result
- actual_target  out  16  computed target (B: PC_next + (sext(imm9)<<1); BR: rs_data)
- wen_BTB, wen_BHT  out  1 each  predictor write enables
- update_PC  out  1  redirect fetch this cycle; also the IF flush
- redirect_PC  out  16  redirect address
- stall_branch  out  1  hold PC and IF/ID
- branch_count, mispredict_count  out  16 each  saturating counters

## Operation
- Conditions (ccc = instr[11:9]): 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GTE Z=1|(Z=0&N=0); 101 LTE N=1|Z=1; 110 OV V=1; 111 always.
- imm9 = instr[8:0], sign-extended to 16 bits and shifted left 1. Add is mod 2^16 and wraps with no flag effect. BR register field is instr[7:4] and is used only externally.
- ready = !flags_pending & (B | rs_ready). Unconditional ccc=111 still waits on flags_pending, for uniformity.
- FSM states IDLE, WAIT, DONE:
  - IDLE with branch & !ready -> WAIT.
  - IDLE with branch & ready: fire. Stay in IDLE if id_advance, else go to DONE.
  - WAIT & ready: fire. Go to IDLE if id_advance, else DONE.
  - DONE: no fire. Go to IDLE when id_advance.
- stall_branch = is_branch & !ready & (state != DONE).
- mispredicted = IF_ID_prediction[1] != actual_taken. target_miscomputed = IF_ID_predicted_target != actual_target.
- On fire:
  - wen_BHT = mispredicted.
  - wen_BTB = actual_taken | target_miscomputed.
  - update_PC = (actual_taken & (mispredicted | target_miscomputed)) | (IF_ID_prediction[1] & !actual_taken).
  - redirect_PC = actual_taken ? actual_target : IF_ID_PC_next.
- When not firing, wen_BTB, wen_BHT and update_PC are 0. actual_taken is 0 when !is_branch.
- Counters, on fire: branch_count += 1; mispredict_count += 1 if update_PC. Both saturate at 0xFFFF.

## Timing
- Reset: state IDLE, counters 0x0000. During the rst cycle wen_BTB, wen_BHT, update_PC and stall_branch are forced 0.
- Resolution is combinational in the fire cycle. The predictor and PC register capture on the next posedge, for a 1-cycle redirect penalty.
- A branch fires exactly once per instance, regardless of how long id_advance is held low.
- flags_pending and rs_ready are sampled every cycle while in WAIT. There is no timeout.
- rst asserted in WAIT or DONE returns to IDLE with no fire and no counter change.
- Counter increments are visible the cycle after fire.

## Test plan
- B EQ 0xC204, Z=1, PC_next=0x0010, prediction 00, id_advance=1 -> actual_target 0x0018, wen_BHT=1, wen_BTB=1, update_PC=1, redirect_PC=0x0018, mispredict_count becomes 1.
- B NE 0xC004, Z=1, prediction 10, predicted_target 0x0018, PC_next=0x0010 -> actual_taken=0, wen_BHT=1, wen_BTB=0, update_PC=1, redirect_PC=0x0010.
- B 0xC3FF (imm=-1), ccc=001, Z=1, PC_next=0x0000, prediction 11, predicted_target 0xFFFE -> target 0xFFFE (wrap), wen_BTB=1, wen_BHT=0, update_PC=0.
- BR 0xDE30, flags_pending=1 for 2 cycles with rs_ready=1, rs_data=0x1234 -> stall_branch=1 for 2 cycles, then a single fire with redirect_PC=0x1234 and branch_count +1.
- Ready branch with id_advance=0 for 3 cycles -> fire in cycle 1 only, DONE in cycles 2-3 with all enables 0, IDLE after advance.
- Preload mispredict_count=0xFFFF, then a mispredicted branch -> count stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decode-stage branch resolution, predictor feedback and fetch redirect
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_advance,
  input  logic [15:0] IF_ID_instr,
  input  logic [15:0] IF_ID_PC_next,
  input  logic [1:0]  IF_ID_prediction,
  input  logic [15:0] IF_ID_predicted_target,
  input  logic        ZF,
  input  logic        VF,
  input  logic        NF,
  input  logic        flags_pending,
  input  logic [15:0] rs_data,
  input  logic        rs_ready,
  output logic        is_branch,
  output logic        actual_taken,
  output logic [15:0] actual_target,
  output logic        wen_BTB,
  output logic        wen_BHT,
  output logic        update_PC,
  output logic [15:0] redirect_PC,
  output logic        stall_branch,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  logic is_b, is_br, cond, ready, fire, mispredicted, target_miscomputed;
  // decode the ID instruction and resolve condition and target
  always_comb begin
    is_b = IF_ID_instr[15:12] == 4'b1100;
    is_br = IF_ID_instr[15:12] == 4'b1101;
    is_branch = is_b | is_br;
    case (IF_ID_instr[11:9])
      3'b000:  cond = !ZF;
      3'b001:  cond = ZF;
      3'b010:  cond = !ZF & !NF;
      3'b011:  cond = NF;
      3'b100:  cond = ZF | (!ZF & !NF);
      3'b101:  cond = NF | ZF;
      3'b110:  cond = VF;
      default: cond = 1'b1;
    endcase
    actual_taken = is_branch & cond;
    actual_target = is_br ? rs_data : IF_ID_PC_next + {{6{IF_ID_instr[8]}}, IF_ID_instr[8:0], 1'b0};
    ready = !flags_pending & (is_b | rs_ready);
    mispredicted = IF_ID_prediction[1] != actual_taken;
    target_miscomputed = IF_ID_predicted_target != actual_target;
  end
  // one fire per branch instance: DONE absorbs the cycles ID is held after firing
  always_comb begin
    state_d = state_q;
    fire = 1'b0;
    case (state_q)
      IDLE: if (is_branch) begin
        fire = ready;
        state_d = !ready ? WAIT : id_advance ? IDLE : DONE;
      end
      WAIT: if (ready) begin
        fire = 1'b1;
        state_d = id_advance ? IDLE : DONE;
      end
      DONE: if (id_advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fire = fire & !rst;
    wen_BHT = fire & mispredicted;
    wen_BTB = fire & (actual_taken | target_miscomputed);
    update_PC = fire & ((actual_taken & (mispredicted | target_miscomputed)) | (IF_ID_prediction[1] & !actual_taken));
    redirect_PC = actual_taken ? actual_target : IF_ID_PC_next;
    stall_branch = !rst & is_branch & !ready & (state_q != DONE);
    branch_count_d = (fire && branch_count_q != 16'hFFFF) ? branch_count_q + 16'd1 : branch_count_q;
    mispredict_count_d = (update_PC && mispredict_count_q != 16'hFFFF) ? mispredict_count_q + 16'd1 : mispredict_count_q;
    branch_count = branch_count_q;
    mispredict_count = mispredict_count_q;
  end
  // state and saturating counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      branch_count_q <= 16'h0000;
      mispredict_count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      branch_count_q <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
endmodule
